// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: the stage-register
// control states and the payload widths of each RISC-V pipeline boundary.
package pipe_pkg;

  // The encoding equals the number of held entries, so occupancy is the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // IF/ID: Instr 32, PC 32, PCPlus4 32
  localparam int unsigned IFID_W  = 96;
  // ID/EX: RegWrite 1, ResultSrc 2, MemWrite 1, Jump 1, Branch 1, ALUControl 3,
  //        ALUSrc 1, RD1 32, RD2 32, PC 32, Rs1 5, Rs2 5, Rd 5, ImmExt 32, PCPlus4 32
  localparam int unsigned IDEX_W  = 185;
  // EX/MEM: RegWrite 1, ResultSrc 2, MemWrite 1, ALUResult 32, WriteData 32,
  //         Rd 5, PCPlus4 32
  localparam int unsigned EXMEM_W = 105;
  // MEM/WB: RegWrite 1, ResultSrc 2, ReadData 32, ALUResult 32, Rd 5, PCPlus4 32
  localparam int unsigned MEMWB_W = 104;

  // Number of entries held in a given state.
  function automatic logic [1:0] occ_of(input pipe_state_t s);
    return logic'(s == TWO) ? 2'd2 : (s == ONE) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit payload register with load enable, cleared by asynchronous reset.
module pipe_data_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold the payload until loaded; clear on reset.
  // NOTE: payload registers are reset to 0 so out_data is deterministic
  // after reset even though it is only meaningful while out_valid is high.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset)     q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, flush, and an
// optional second (skid) entry that allows in_ready to come from a flop.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter bit          SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic             main_from_skid;
  logic             skid_load;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign out_valid = (state_q != EMPTY);
  assign occupancy = occ_of(state_q);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Next-state and data-load decisions; flush overrides every transition
  // and suppresses all loads so the data registers simply hold.
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = ONE;
          main_load = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          // Only reachable with a skid entry; without one in_ready needs out_ready.
          state_d   = TWO;
          skid_load = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d        = ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d   = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (out_data)
  );

  generate
    if (SKID) begin : g_skid
      logic in_ready_q;

      pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
      );

      // Registered ready: accept whenever the next state still has a free entry.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) in_ready_q <= 1'b1;
        else       in_ready_q <= (state_d != TWO);
      end

      assign in_ready = in_ready_q;
    end else begin : g_single
      assign skid_q   = '0;
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic parametrised pipeline stage register for the RISC-V pipeline, replacing per-stage hand-packed registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a packed payload of WIDTH bits between stages with a valid/ready handshake, stage flush, and optional 2-entry skid buffering so that `in_ready` is fully registered. Each stage instantiates one copy, packing its control and data fields into `in_data`.

## Interface
- WIDTH, 32: payload width in bits, 1..256.
- SKID, 1: 1 = two-entry skid mode with registered `in_ready`; 0 = single-entry mode with combinational `in_ready`.
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept the payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  payload valid to downstream.
- out_ready  input  1  downstream accepts (deasserted = stall).
- out_data  output  WIDTH  payload to downstream, driven directly from the main register.
- flush  input  1  kill every held entry and any incoming transfer this cycle.
- occupancy  output  2  number of held entries, 0..2.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
  - Order is strict FIFO.
- States: EMPTY (occ 0), ONE (occ 1, main valid), TWO (occ 2, main and skid valid; SKID=1 only).
- Transitions when `flush` = 0:
  - EMPTY + in → ONE; main ← in_data.
  - ONE + out, no in → EMPTY.
  - ONE + in + out → ONE; main ← in_data.
  - ONE + in, no out → TWO; skid ← in_data.
  - TWO + out → ONE; main ← skid.
  - In TWO, `in_ready` = 0, so no input transfer is possible.
- `in_ready`:
  - SKID=1: `in_ready` = (state != TWO), from a register.
  - SKID=0: `in_ready` = !out_valid || out_ready. The ONE + in, no out case cannot occur.
- Flush:
  - Any cycle with `flush` = 1 goes to EMPTY next cycle.
  - An input transfer in the same cycle still handshakes, and its data is dropped.
  - A concurrent output transfer completes normally.
  - Flush has priority over every other transition.
- Data registers:
  - They load only on the transitions listed above. Otherwise they hold, including under flush.
  - `out_data` is undefined-by-contract while `out_valid` = 0, but is deterministic: it keeps the last loaded value.
- Stall: while `out_ready` = 0 and the state is ONE or TWO, `out_data` and `out_valid` hold stable.

## Timing
- Reset value of every output: out_valid=0, out_data=0, skid data=0, occupancy=0, state EMPTY.
  - SKID=1: in_ready=1.
  - SKID=0: in_ready=1 (combinational, because out_valid=0).
- Reset is asynchronous. An assertion mid-operation clears state immediately and discards held entries.
- Latency: in_data accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 when the stage was EMPTY, or was ONE with out fire.
- Throughput: 1 transfer/cycle sustained in both modes while `out_ready` = 1.
- SKID=1: after out_ready falls, one more input is absorbed into skid, then in_ready=0 from the next cycle.
- `occupancy` is registered and reflects the state after the last clock edge.

## Structure
- Shared package `pipe_pkg`:
  - state enum `pipe_state_t` {EMPTY, ONE, TWO}.
  - localparam widths for the stage payloads, e.g. MEMWB_W = 104 (RegWrite 1, ResultSrc 2, ReadData 32, ALUResult 32, Rd 5, PCPlus4 32).
- Sub-module `pipe_data_reg`: WIDTH-bit register with async active-high reset to 0 and load enable. Instantiated twice (main, skid); the skid instance is generated only when SKID=1.
- The control FSM is in the top module.

## Test plan
- Reset: hold reset=1, apply in_valid=1 with in_data=32'hDEADBEEF → out_valid=0, out_data=0, occupancy=0, in_ready=1. Release reset; accept one beat → out_data=32'hDEADBEEF, out_valid=1 next cycle.
- Streaming, SKID=1 and SKID=0, out_ready=1: beats 1..8 on consecutive cycles → beats 1..8 out one cycle later, no gaps, occupancy stays 1.
- Stall (SKID=1): out_ready=0 while streaming A, B, C → A held on out, B in skid, in_ready=0 and C held upstream. Release → A, B, C out in order, one per cycle.
- Flush (SKID=1): in state TWO, with in_valid=0, flush=1 → next cycle out_valid=0, occupancy=0, in_ready=1; out_data keeps the old value. Separately, flush together with in_valid=1 in EMPTY → beat dropped, out_valid stays 0.
- Async reset mid-operation: assert reset between edges in state TWO → outputs go to reset values without waiting for a clock edge.
- WIDTH=104 (MEMWB_W) with SKID=0: randomised in_valid/out_ready against a scoreboard → no loss, no duplication, and in_ready == !out_valid || out_ready every cycle.
